// File: rtl/dout_framer.sv
// Output framer for the pixel app's 64-bit dout stream: buffers words in a FIFO
// with a registered head and tags each word with a frame-end flag.
module dout_framer #(
    parameter int unsigned LOGDEPTH    = 4,
    parameter int unsigned FRAME_WORDS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [63:0]         in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_flush,
    output logic [63:0]         out_data,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready,
    output logic [15:0]         frame_count,
    output logic [LOGDEPTH:0]   level
);

    localparam int unsigned DEPTH = 1 << LOGDEPTH;
    localparam int unsigned LW    = LOGDEPTH + 1;
    localparam logic [LW-1:0] FULL     = LW'(DEPTH);
    localparam logic [15:0]   LAST_CNT = 16'(FRAME_WORDS - 1);

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } word_t;

    word_t               mem [DEPTH];
    logic [LOGDEPTH-1:0] wr_ptr;
    logic [LOGDEPTH-1:0] rd_ptr;
    logic [LOGDEPTH-1:0] rd_ptr_nxt;
    logic [LW-1:0]       level_nxt;
    logic [15:0]         wr_cnt;
    logic                wr_en;
    logic                rd_en;
    logic                wr_last;
    logic                bypass;
    word_t               head_nxt;

    // Transfer decode, next occupancy and the word that will sit at the head.
    always_comb begin
        wr_en      = in_valid && in_ready;
        rd_en      = out_valid && out_ready;
        wr_last    = (wr_cnt == LAST_CNT) || in_flush;
        rd_ptr_nxt = rd_en ? rd_ptr + LOGDEPTH'(1) : rd_ptr;
        level_nxt  = level;
        case ({wr_en, rd_en})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
        // The incoming word becomes the head when nothing older remains after this read.
        bypass = wr_en && (wr_ptr == rd_ptr_nxt);
        if (bypass) begin
            head_nxt.last = wr_last;
            head_nxt.data = in_data;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // Storage array; contents are don't-care once pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= word_t'({wr_last, in_data});
        end
    end

    // Pointers, framing counter, occupancy and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_cnt      <= '0;
            level       <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            frame_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + LOGDEPTH'(1);
                wr_cnt <= wr_last ? 16'd0 : wr_cnt + 16'd1;
            end
            rd_ptr    <= rd_ptr_nxt;
            level     <= level_nxt;
            in_ready  <= (level_nxt != FULL);
            out_valid <= (level_nxt != '0);
            out_data  <= (level_nxt != '0) ? head_nxt.data : 64'd0;
            out_last  <= (level_nxt != '0) ? head_nxt.last : 1'b0;
            if (rd_en && out_last) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dout_framer.sv
// Scoreboard bench for dout_framer: two instances (4- and 7-word frames) share
// one stimulus stream and are checked against a queue-based reference model.
module tb_dout_framer;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [63:0] d;
        logic        l4;
        logic        l7;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b1;
    logic        in_flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready4, out_valid4, out_last4;
    logic [63:0] out_data4;
    logic [15:0] fc4;
    logic [4:0]  level4;
    logic        in_ready7, out_valid7, out_last7;
    logic [63:0] out_data7;
    logic [15:0] fc7;
    logic [4:0]  level7;

    int n_cmp = 0;
    int n_err = 0;
    bit rnd_mode = 1'b0;

    exp_t        sb[$];
    int          cnt4 = 0;
    int          cnt7 = 0;
    logic [15:0] exp_fc4 = '0;
    logic [15:0] exp_fc7 = '0;
    logic        rst_last = 1'b1;

    dout_framer #(.LOGDEPTH(4), .FRAME_WORDS(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready4), .in_flush(in_flush), .out_data(out_data4),
        .out_valid(out_valid4), .out_last(out_last4), .out_ready(out_ready),
        .frame_count(fc4), .level(level4)
    );

    dout_framer #(.LOGDEPTH(4), .FRAME_WORDS(7)) u_dut7 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready7), .in_flush(in_flush), .out_data(out_data7),
        .out_valid(out_valid7), .out_last(out_last7), .out_ready(out_ready),
        .frame_count(fc7), .level(level7)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Monitor and reference model: checks what the DUTs show, then applies the coming edge.
    always @(negedge clk) begin
        exp_t h;
        exp_t e;
        logic ev;
        logic er;
        ev = (sb.size() != 0);
        er = !rst_last && (sb.size() != DEPTH);
        h  = ev ? sb[0] : '0;
        chk("level4", 64'(level4), 64'(sb.size()));
        chk("level7", 64'(level7), 64'(sb.size()));
        chk("in_ready4", 64'(in_ready4), 64'(er));
        chk("in_ready7", 64'(in_ready7), 64'(er));
        chk("out_valid4", 64'(out_valid4), 64'(ev));
        chk("out_valid7", 64'(out_valid7), 64'(ev));
        chk("out_data4", out_data4, h.d);
        chk("out_data7", out_data7, h.d);
        chk("out_last4", 64'(out_last4), 64'(h.l4));
        chk("out_last7", 64'(out_last7), 64'(h.l7));
        chk("frame_count4", 64'(fc4), 64'(exp_fc4));
        chk("frame_count7", 64'(fc7), 64'(exp_fc7));
        if (rst) begin
            sb.delete();
            cnt4 = 0;
            cnt7 = 0;
            exp_fc4 = '0;
            exp_fc7 = '0;
        end else begin
            if (ev && out_ready) begin
                void'(sb.pop_front());
                if (h.l4) exp_fc4 = exp_fc4 + 16'd1;
                if (h.l7) exp_fc7 = exp_fc7 + 16'd1;
            end
            if (in_valid && er) begin
                e.d  = in_data;
                e.l4 = (cnt4 == 3) || in_flush;
                e.l7 = (cnt7 == 6) || in_flush;
                cnt4 = e.l4 ? 0 : cnt4 + 1;
                cnt7 = e.l7 ? 0 : cnt7 + 1;
                sb.push_back(e);
            end
        end
        rst_last = rst;
    end

    // Random sink back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rnd_mode) out_ready = 1'($urandom_range(1));
    end

    task automatic send(input logic [63:0] d, input logic f);
        bit acc;
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_flush = f;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            acc = in_ready4;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout("send");
        in_valid = 1'b0;
        in_flush = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (level4 == 0 && level7 == 0 && !out_valid4 && !out_valid7) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) timeout("drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with in_valid held high: nothing may be written.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready4), 64'd0);
        chk("rst_level", 64'(level4), 64'd0);
        chk("rst_frame_count", 64'(fc4), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready4), 64'd1);
        chk("post_rst_level", 64'(level4), 64'd0);
        @(posedge clk);
        #1;

        // Back-to-back words, always-ready sink.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(64'(i), 1'b0);
        wait_empty();
        chk("b2b_frames4", 64'(fc4), 64'd2);
        chk("b2b_frames7", 64'(fc7), 64'd1);

        // Fill to full with sink stalled, then release.
        do_reset(1);
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 17; i++) send(64'h100 + 64'(i), 1'b0);
            begin
                bit seen;
                seen = 1'b0;
                for (int t = 0; t < 200; t++) begin
                    @(negedge clk);
                    if (level4 == 5'd16) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) timeout("fill");
                repeat (3) @(negedge clk);
                chk("full_level", 64'(level4), 64'd16);
                chk("full_in_ready", 64'(in_ready4), 64'd0);
                chk("full_head", out_data4, 64'h100);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                chk("ready_after_pop", 64'(in_ready4), 64'd1);
            end
        join
        wait_empty();

        // Flush on the second word, then a full frame.
        do_reset(1);
        for (int i = 0; i < 6; i++) send(64'h200 + 64'(i), i == 1);
        wait_empty();
        chk("flush_frames4", 64'(fc4), 64'd2);
        chk("flush_frames7", 64'(fc7), 64'd1);

        // Random valid/ready traffic.
        do_reset(2);
        rnd_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            while ($urandom_range(1) == 0) begin
                @(posedge clk);
                #1;
            end
            send({$urandom, $urandom}, 1'b0);
        end
        rnd_mode = 1'b0;
        #0 out_ready = 1'b1;
        wait_empty();
        chk("rand_frames4", 64'(fc4), 64'd250);
        chk("rand_frames7", 64'(fc7), 64'd142);

        // Reset mid-frame with words buffered.
        do_reset(1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(64'h300 + 64'(i), i == 2);
        @(negedge clk);
        chk("pre_rst_level", 64'(level4), 64'd5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_level", 64'(level4), 64'd0);
        chk("mid_rst_valid", 64'(out_valid4), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(64'h400 + 64'(i), 1'b0);
        wait_empty();
        chk("mid_rst_frames4", 64'(fc4), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
